// File: rtl/guessing_game_n.sv
// Reaction game core: lights one of N targets per timed window, scores button presses
// against it, and latches WIN or LOSE once the hit or miss limit is reached.
//
// state | meaning
// IDLE  | display dark, waiting for any press to start
// RUN   | target lit, first press or window expiry decides hit/miss
// HIT   | all LEDs on for one window, then next target or WIN
// MISS  | all LEDs off for one window, then next target or LOSE
// WIN   | alternating pattern toggling each window, held until reset
// LOSE  | display dark, held until reset
module guessing_game_n #(
   parameter int N         = 4,
   parameter int TICK_DIV  = 25_000_000,
   parameter int SCORE_W   = 4,
   parameter int WIN_SCORE = 10,
   parameter int MAX_MISS  = 3
) (
   input  logic               clk,
   input  logic               btnC,
   input  logic [N-1:0]       btn,
   input  logic [1:0]         speed,
   input  logic               mode,
   output logic [N-1:0]       led,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] misses,
   output logic               win,
   output logic               lose
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int TW = $clog2(TICK_DIV + 1);
   localparam logic [N-1:0] ALT = {(N/2){2'b01}};

   typedef enum logic [2:0] {IDLE, RUN, HIT, MISS, WIN, LOSE} state_t;

   state_t             state, state_nx;
   logic [TW-1:0]      tick, tick_nx;
   logic [TW-1:0]      period, period_nx;
   logic [TW-1:0]      new_period;
   logic [IW-1:0]      idx, idx_nx, idx_step;
   logic [7:0]         lfsr;
   logic               lfsr_fb;
   logic [N-1:0]       led_nx, tgt;
   logic [SCORE_W-1:0] score_nx, misses_nx;
   logic               expire;

   assign new_period = TW'(TICK_DIV >> speed);
   assign expire     = (tick == period - 1'b1);
   assign tgt        = N'(1) << idx;
   assign idx_step   = mode ? lfsr[IW-1:0] : idx + 1'b1;
   assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

   always_comb begin
      state_nx  = state;
      tick_nx   = tick + 1'b1;
      period_nx = period;
      idx_nx    = idx;
      led_nx    = led;
      score_nx  = score;
      misses_nx = misses;
      unique case (state)
         IDLE: begin
            tick_nx = '0;
            led_nx  = '0;
            if (|btn) begin
               state_nx  = RUN;
               idx_nx    = '0;
               period_nx = new_period;
               led_nx    = N'(1);
            end
         end
         RUN: begin
            // a press on the expiry cycle wins over the timeout
            if (btn == tgt) begin
               state_nx  = HIT;
               score_nx  = score + 1'b1;
               tick_nx   = '0;
               period_nx = new_period;
               led_nx    = '1;
            end else if ((btn != '0) || expire) begin
               state_nx  = MISS;
               misses_nx = misses + 1'b1;
               tick_nx   = '0;
               period_nx = new_period;
               led_nx    = '0;
            end
         end
         HIT, MISS: begin
            if (expire) begin
               tick_nx   = '0;
               period_nx = new_period;
               if ((state == HIT) && (score == SCORE_W'(WIN_SCORE))) begin
                  state_nx = WIN;
                  led_nx   = ALT;
               end else if ((state == MISS) && (misses == SCORE_W'(MAX_MISS))) begin
                  state_nx = LOSE;
                  led_nx   = '0;
               end else begin
                  state_nx = RUN;
                  idx_nx   = idx_step;
                  led_nx   = N'(1) << idx_step;
               end
            end
         end
         WIN: begin
            if (expire) begin
               tick_nx = '0;
               led_nx  = ~led;
            end
         end
         LOSE: begin
            tick_nx = '0;
            led_nx  = '0;
         end
         default: begin
            state_nx = IDLE;
            tick_nx  = '0;
            led_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (btnC) begin
         state  <= IDLE;
         tick   <= '0;
         period <= TW'(TICK_DIV);
         idx    <= '0;
         lfsr   <= 8'h01;
         led    <= '0;
         score  <= '0;
         misses <= '0;
         win    <= 1'b0;
         lose   <= 1'b0;
      end else begin
         state  <= state_nx;
         tick   <= tick_nx;
         period <= period_nx;
         idx    <= idx_nx;
         lfsr   <= {lfsr[6:0], lfsr_fb};
         led    <= led_nx;
         score  <= score_nx;
         misses <= misses_nx;
         win    <= (state_nx == WIN);
         lose   <= (state_nx == LOSE);
      end
   end
endmodule

// File: tb/tb_guessing_game_n.sv
// Directed bench for guessing_game_n (N=4, TICK_DIV=16, WIN_SCORE=3, MAX_MISS=3) with
// a queue of expected output vectors drained after each observed clock edge.
module tb_guessing_game_n;
   logic       clk = 1'b0;
   logic       btnC;
   logic [3:0] btn;
   logic [1:0] speed;
   logic       mode;
   logic [3:0] led;
   logic [3:0] score;
   logic [3:0] misses;
   logic       win;
   logic       lose;

   typedef struct {
      string       tag;
      logic [13:0] v;
   } exp_t;

   exp_t       sb[$];
   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] m_lfsr;

   guessing_game_n #(.N(4), .TICK_DIV(16), .SCORE_W(4), .WIN_SCORE(3), .MAX_MISS(3)) dut (
      .clk(clk), .btnC(btnC), .btn(btn), .speed(speed), .mode(mode),
      .led(led), .score(score), .misses(misses), .win(win), .lose(lose)
   );

   always #5 clk = ~clk;

   // reference LFSR, x^8+x^6+x^5+x^4+1, reset to 8'h01
   always @(posedge clk) begin
      if (btnC) m_lfsr <= 8'h01;
      else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time %0t exceeded, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic press(input logic [3:0] b);
      btn = b;
      cyc(1);
      btn = '0;
   endtask

   task automatic expect_out(input string tag, input logic [3:0] l, input logic [3:0] s,
                             input logic [3:0] m, input logic w, input logic lo);
      exp_t e;
      e.tag = tag;
      e.v   = {l, s, m, w, lo};
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t        e;
      logic [13:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = {led, score, misses, win, lose};
         n_vec++;
         assert (obs === e.v) else begin
            n_err++;
            $error("FAIL %s: observed led/score/misses/win/lose=%h required=%h", e.tag, obs, e.v);
         end
      end
   endtask

   task automatic do_reset();
      btnC = 1'b1;
      cyc(1);
      btnC = 1'b0;
   endtask

   initial begin
      logic [7:0] snap;
      int         cur;
      int         s_e;
      int         m_e;
      btnC  = 1'b1;
      btn   = '0;
      speed = 2'd0;
      mode  = 1'b0;
      @(negedge clk);

      // reset held two cycles with all buttons pressed in between
      cyc(1);
      btn = 4'b1111;
      cyc(1);
      btn  = '0;
      btnC = 1'b0;
      expect_out("reset", 4'b0000, 0, 0, 0, 0);
      drain();
      cyc(2);
      expect_out("idle_hold", 4'b0000, 0, 0, 0, 0);
      drain();

      // rotate mode, P = 16, hit every target
      press(4'b0100);
      expect_out("start", 4'b0001, 0, 0, 0, 0);
      drain();
      cyc(3);
      press(4'b0001);
      expect_out("hit1", 4'b1111, 1, 0, 0, 0);
      drain();
      cyc(15);
      expect_out("hit1_hold", 4'b1111, 1, 0, 0, 0);
      drain();
      cyc(1);
      expect_out("run2", 4'b0010, 1, 0, 0, 0);
      drain();
      press(4'b0010);
      expect_out("hit2", 4'b1111, 2, 0, 0, 0);
      drain();
      cyc(16);
      expect_out("run3", 4'b0100, 2, 0, 0, 0);
      drain();
      cyc(15);
      expect_out("run3_expiry", 4'b0100, 2, 0, 0, 0);
      drain();
      press(4'b0100);
      expect_out("hit_on_expiry", 4'b1111, 3, 0, 0, 0);
      drain();
      cyc(16);
      expect_out("win_entry", 4'b0101, 3, 0, 1, 0);
      drain();
      cyc(15);
      expect_out("win_hold", 4'b0101, 3, 0, 1, 0);
      drain();
      cyc(1);
      expect_out("win_toggle", 4'b1010, 3, 0, 1, 0);
      drain();
      press(4'b1111);
      expect_out("win_ignores_btn", 4'b1010, 3, 0, 1, 0);
      drain();

      // timeout loss at P = 8
      do_reset();
      speed = 2'd1;
      press(4'b0001);
      expect_out("to_start", 4'b0001, 0, 0, 0, 0);
      drain();
      for (int k = 1; k <= 3; k++) begin
         cyc(7);
         expect_out($sformatf("to_run%0d_end", k), 4'(1 << (k - 1)), 0, 4'(k - 1), 0, 0);
         drain();
         cyc(1);
         expect_out($sformatf("to_miss%0d", k), 4'b0000, 0, 4'(k), 0, 0);
         drain();
         cyc(7);
         expect_out($sformatf("to_miss%0d_hold", k), 4'b0000, 0, 4'(k), 0, 0);
         drain();
         cyc(1);
         if (k < 3) expect_out($sformatf("to_run%0d", k + 1), 4'(1 << k), 0, 4'(k), 0, 0);
         else       expect_out("to_lose", 4'b0000, 0, 3, 0, 1);
         drain();
      end
      press(4'b0001);
      press(4'b1111);
      expect_out("lose_hold", 4'b0000, 0, 3, 0, 1);
      drain();

      // wrong and multi-bit presses, P = 16
      do_reset();
      speed = 2'd0;
      press(4'b1000);
      press(4'b0001);
      expect_out("wm_hit", 4'b1111, 1, 0, 0, 0);
      drain();
      cyc(16);
      expect_out("wm_run", 4'b0010, 1, 0, 0, 0);
      drain();
      press(4'b0100);
      expect_out("wrong_press", 4'b0000, 1, 1, 0, 0);
      drain();
      cyc(16);
      expect_out("wm_run2", 4'b0100, 1, 1, 0, 0);
      drain();
      press(4'b0011);
      expect_out("multi_press", 4'b0000, 1, 2, 0, 0);
      drain();
      cyc(16);
      expect_out("wm_run3", 4'b1000, 1, 2, 0, 0);
      drain();

      // reset coincident with a correct press
      btn  = 4'b1000;
      btnC = 1'b1;
      cyc(1);
      btn  = '0;
      btnC = 1'b0;
      expect_out("reset_vs_press", 4'b0000, 0, 0, 0, 0);
      drain();

      // random mode, P = 8: targets follow lfsr[1:0] at each window start
      mode  = 1'b1;
      speed = 2'd1;
      s_e   = 0;
      m_e   = 0;
      press(4'b0010);
      cur = 0;
      expect_out("rnd_start", 4'b0001, 0, 0, 0, 0);
      drain();
      for (int w = 0; w < 4; w++) begin
         if (w % 2 == 0) begin
            press(4'(1 << cur));
            s_e++;
            expect_out($sformatf("rnd_hit%0d", w), 4'b1111, 4'(s_e), 4'(m_e), 0, 0);
         end else begin
            press(4'b1111 ^ 4'(1 << cur));
            m_e++;
            expect_out($sformatf("rnd_miss%0d", w), 4'b0000, 4'(s_e), 4'(m_e), 0, 0);
         end
         drain();
         cyc(7);
         snap = m_lfsr;
         cyc(1);
         cur = int'(snap[1:0]);
         expect_out($sformatf("rnd_tgt%0d", w), 4'(1 << cur), 4'(s_e), 4'(m_e), 0, 0);
         drain();
      end
      press(4'(1 << cur));
      expect_out("rnd_hit_last", 4'b1111, 3, 2, 0, 0);
      drain();
      cyc(8);
      expect_out("rnd_win", 4'b0101, 3, 2, 1, 0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
